// File: rtl/mmu_pkg.sv
// Shared MMU types: TLB op codes, sequencer states and the mmu TLB-instruction port structs.
package mmu_pkg;

   localparam int TLB_ENTRIES = 16;
   localparam int INDEX_W     = $clog2(TLB_ENTRIES);

   typedef logic [INDEX_W-1:0] tlb_index_t;

   typedef enum logic [1:0] {
      TLBP  = 2'd0,
      TLBR  = 2'd1,
      TLBWI = 2'd2,
      TLBWR = 2'd3
   } tlb_op_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_COMMIT  = 2'd3
   } tlb_ctrl_state_t;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [4:0]  rsvd;
      logic [7:0]  asid;
   } entry_hi_t;

   typedef struct packed {
      entry_hi_t   entry_hi;
      logic [31:0] entry_lo0;
      logic [31:0] entry_lo1;
      tlb_index_t  index;
      tlb_index_t  random;
      logic        is_tlbwi;
      logic        is_tlbwr;
   } mmu_req_t;

   // index carries the probe result with the P (miss) flag in bit 31
   typedef struct packed {
      logic [31:0] index;
      logic [31:0] entry_hi;
      logic [31:0] entry_lo0;
      logic [31:0] entry_lo1;
   } mmu_resp_t;

endpackage

// File: rtl/tlb_random.sv
// CP0 Random register: free-running down-counter that wraps to the top entry at Wired.
module tlb_random
   import mmu_pkg::*;
#(
   parameter int TLB_ENTRIES = mmu_pkg::TLB_ENTRIES,
   parameter int INDEX_W     = mmu_pkg::INDEX_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wired_we,
   input  logic [INDEX_W-1:0] cp0_wired,
   output logic [INDEX_W-1:0] random
);

   localparam logic [INDEX_W-1:0] TOP = INDEX_W'(TLB_ENTRIES - 1);

   logic [INDEX_W-1:0] r_random;
   logic               w_wrap;

   // <= rather than == so a Wired raised above Random never lets it slip lower
   assign w_wrap = (r_random <= cp0_wired) || (cp0_wired >= TOP);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_random <= TOP;
      end else if (wired_we) begin
         r_random <= TOP;
      end else if (w_wrap) begin
         r_random <= TOP;
      end else begin
         r_random <= r_random - 1'b1;
      end
   end

   assign random = r_random;

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLBP/TLBR/TLBWI/TLBWR sequencer: snapshots CP0 operands, drives the mmu port for one
// cycle, registers the probe/read result and commits CP0 writeback plus a refetch request.
module tlb_op_ctrl
   import mmu_pkg::*;
#(
   parameter int TLB_ENTRIES = mmu_pkg::TLB_ENTRIES,
   parameter int INDEX_W     = mmu_pkg::INDEX_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   input  logic [1:0]         req_op,
   output logic               req_ready,
   input  logic               kill,
   input  logic [31:0]        cp0_entry_hi,
   input  logic [31:0]        cp0_entry_lo0,
   input  logic [31:0]        cp0_entry_lo1,
   input  logic [31:0]        cp0_index,
   input  logic [INDEX_W-1:0] cp0_wired,
   input  logic               wired_we,
   output mmu_req_t           mmu_in,
   input  mmu_resp_t          mmu_out,
   output logic [INDEX_W-1:0] random,
   output logic               index_we,
   output logic [31:0]        index_wdata,
   output logic               entry_we,
   output logic [31:0]        entry_hi_wdata,
   output logic [31:0]        entry_lo0_wdata,
   output logic [31:0]        entry_lo1_wdata,
   output logic               done,
   output logic               flush_req,
   output logic               busy
);

   tlb_ctrl_state_t    r_state;
   tlb_ctrl_state_t    w_state_next;
   tlb_op_t            r_op;
   logic [31:0]        r_hi;
   logic [31:0]        r_lo0;
   logic [31:0]        r_lo1;
   logic [INDEX_W-1:0] r_index;
   logic [INDEX_W-1:0] r_random_snap;
   logic [31:0]        r_index_wdata;
   logic [31:0]        r_hi_wdata;
   logic [31:0]        r_lo0_wdata;
   logic [31:0]        r_lo1_wdata;
   logic [INDEX_W-1:0] w_random;
   logic               w_accept;
   logic               w_is_write;
   logic               w_unused;

   tlb_random #(
      .TLB_ENTRIES (TLB_ENTRIES),
      .INDEX_W     (INDEX_W)
   ) u_random (
      .clk       (clk),
      .reset     (reset),
      .wired_we  (wired_we),
      .cp0_wired (cp0_wired),
      .random    (w_random)
   );

   assign w_accept   = (r_state == ST_IDLE) && req_valid && !kill;
   assign w_is_write = (r_op == TLBWI) || (r_op == TLBWR);
   assign w_unused   = ^{cp0_index[31:INDEX_W], mmu_out.index[30:INDEX_W]};

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:    if (w_accept) w_state_next = ST_ISSUE;
         ST_ISSUE:   w_state_next = kill ? ST_IDLE : ST_CAPTURE;
         // a write has already reached the TLB, so only reads may still be squashed
         ST_CAPTURE: w_state_next = (kill && !w_is_write) ? ST_IDLE : ST_COMMIT;
         default:    w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_op          <= TLBP;
         r_hi          <= '0;
         r_lo0         <= '0;
         r_lo1         <= '0;
         r_index       <= '0;
         r_random_snap <= '0;
         r_index_wdata <= '0;
         r_hi_wdata    <= '0;
         r_lo0_wdata   <= '0;
         r_lo1_wdata   <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_op          <= tlb_op_t'(req_op);
            r_hi          <= cp0_entry_hi;
            r_lo0         <= cp0_entry_lo0;
            r_lo1         <= cp0_entry_lo1;
            r_index       <= cp0_index[INDEX_W-1:0];
            r_random_snap <= w_random;
         end
         // mmu_out is only meaningful while ISSUE drives the snapshot; hold it for COMMIT
         if (r_state == ST_ISSUE && !kill) begin
            if (r_op == TLBP) begin
               r_index_wdata <= {mmu_out.index[31], {(31 - INDEX_W){1'b0}},
                                 mmu_out.index[INDEX_W-1:0]};
            end
            if (r_op == TLBR) begin
               r_hi_wdata  <= mmu_out.entry_hi;
               r_lo0_wdata <= mmu_out.entry_lo0;
               r_lo1_wdata <= mmu_out.entry_lo1;
            end
         end
      end
   end

   always_comb begin
      mmu_in               = '0;
      mmu_in.entry_hi.asid = cp0_entry_hi[7:0];
      if (r_state == ST_ISSUE) begin
         mmu_in.entry_hi  = entry_hi_t'(r_hi);
         mmu_in.entry_lo0 = r_lo0;
         mmu_in.entry_lo1 = r_lo1;
         mmu_in.index     = r_index;
         mmu_in.random    = r_random_snap;
         mmu_in.is_tlbwi  = (r_op == TLBWI) && !kill;
         mmu_in.is_tlbwr  = (r_op == TLBWR) && !kill;
      end
   end

   assign req_ready       = (r_state == ST_IDLE);
   assign busy            = (r_state != ST_IDLE);
   assign done            = (r_state == ST_COMMIT);
   assign index_we        = done && (r_op == TLBP);
   assign entry_we        = done && (r_op == TLBR);
   assign flush_req       = done && (r_op != TLBP);
   assign random          = w_random;
   assign index_wdata     = r_index_wdata;
   assign entry_hi_wdata  = r_hi_wdata;
   assign entry_lo0_wdata = r_lo0_wdata;
   assign entry_lo1_wdata = r_lo1_wdata;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: behavioural 16-entry TLB on the mmu port, scoreboard of expected
// per-instruction results compared when each instruction has run to completion.
module tb_tlb_op_ctrl;
   import mmu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic [1:0]  req_op = 2'd0;
   logic        req_ready;
   logic        kill = 1'b0;
   logic [31:0] cp0_entry_hi = '0;
   logic [31:0] cp0_entry_lo0 = '0;
   logic [31:0] cp0_entry_lo1 = '0;
   logic [31:0] cp0_index = '0;
   logic [3:0]  cp0_wired = '0;
   logic        wired_we = 1'b0;
   mmu_req_t    mmu_in;
   mmu_resp_t   mmu_out;
   logic [3:0]  random;
   logic        index_we, entry_we, done, flush_req, busy;
   logic [31:0] index_wdata, entry_hi_wdata, entry_lo0_wdata, entry_lo1_wdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   tlb_op_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_op          (req_op),
      .req_ready       (req_ready),
      .kill            (kill),
      .cp0_entry_hi    (cp0_entry_hi),
      .cp0_entry_lo0   (cp0_entry_lo0),
      .cp0_entry_lo1   (cp0_entry_lo1),
      .cp0_index       (cp0_index),
      .cp0_wired       (cp0_wired),
      .wired_we        (wired_we),
      .mmu_in          (mmu_in),
      .mmu_out         (mmu_out),
      .random          (random),
      .index_we        (index_we),
      .index_wdata     (index_wdata),
      .entry_we        (entry_we),
      .entry_hi_wdata  (entry_hi_wdata),
      .entry_lo0_wdata (entry_lo0_wdata),
      .entry_lo1_wdata (entry_lo1_wdata),
      .done            (done),
      .flush_req       (flush_req),
      .busy            (busy)
   );

   // behavioural TLB standing in for mmu
   logic [31:0] m_hi  [16];
   logic [31:0] m_lo0 [16];
   logic [31:0] m_lo1 [16];
   logic        m_v   [16];
   logic        ld_en = 1'b0;
   logic [3:0]  ld_idx = '0;
   logic [31:0] ld_hi = '0, ld_lo0 = '0, ld_lo1 = '0;

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) m_v[i] <= 1'b0;
      end
      if (ld_en) begin
         m_hi[ld_idx] <= ld_hi; m_lo0[ld_idx] <= ld_lo0; m_lo1[ld_idx] <= ld_lo1; m_v[ld_idx] <= 1'b1;
      end
      if (mmu_in.is_tlbwi) begin
         m_hi[mmu_in.index] <= mmu_in.entry_hi; m_lo0[mmu_in.index] <= mmu_in.entry_lo0;
         m_lo1[mmu_in.index] <= mmu_in.entry_lo1; m_v[mmu_in.index] <= 1'b1;
      end
      if (mmu_in.is_tlbwr) begin
         m_hi[mmu_in.random] <= mmu_in.entry_hi; m_lo0[mmu_in.random] <= mmu_in.entry_lo0;
         m_lo1[mmu_in.random] <= mmu_in.entry_lo1; m_v[mmu_in.random] <= 1'b1;
      end
   end

   always_comb begin
      mmu_out.index = 32'h8000_0000;
      for (int i = 0; i < 16; i++) begin
         if (m_v[i] === 1'b1 && m_hi[i][31:13] == mmu_in.entry_hi.vpn2 &&
             m_hi[i][7:0] == mmu_in.entry_hi.asid) mmu_out.index = 32'(i);
      end
      mmu_out.entry_hi  = m_hi[mmu_in.index];
      mmu_out.entry_lo0 = m_lo0[mmu_in.index];
      mmu_out.entry_lo1 = m_lo1[mmu_in.index];
   end

   typedef struct {
      int          done_off;
      int          ready_off;
      int          wi_off;
      int          wr_off;
      int          done_cnt;
      logic        ready0;
      logic        busy_all;
      logic [3:0]  wr_idx;
      logic [3:0]  rnd2;
      logic        index_we;
      logic        entry_we;
      logic        flush;
      logic [31:0] index_wdata;
      logic [31:0] hi;
      logic [31:0] lo0;
      logic [31:0] lo1;
   } obs_t;

   typedef struct {
      int          done_off;
      int          ready_off;
      int          wi_off;
      int          wr_off;
      logic [3:0]  wr_idx;
      logic        index_we;
      logic        entry_we;
      logic        flush;
      logic [31:0] index_wdata;
      logic [31:0] hi;
      logic [31:0] lo0;
      logic [31:0] lo1;
   } exp_t;

   exp_t sb[$];

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic load_entry(input int idx, input logic [31:0] hi, lo0, lo1);
      ld_en = 1'b1; ld_idx = 4'(idx); ld_hi = hi; ld_lo0 = lo0; ld_lo1 = lo1;
      tick();
      ld_en = 1'b0;
   endtask

   // Presents one instruction at offset 0 and records what the DUT does over 7 cycles.
   // CP0 operands are scrambled after acceptance to expose any missing snapshot.
   task automatic run_op(input tlb_op_t op, input int kill_at, input int wired_at, output obs_t o);
      o = '{done_off: -1, ready_off: -1, wi_off: -1, wr_off: -1, done_cnt: 0, ready0: 1'b0,
            busy_all: 1'b1, wr_idx: '0, rnd2: '0, index_we: 1'b0, entry_we: 1'b0, flush: 1'b0,
            index_wdata: '0, hi: '0, lo0: '0, lo1: '0};
      req_valid = 1'b1; req_op = op; kill = (kill_at == 0); wired_we = (wired_at == 0);
      #1;
      o.ready0 = req_ready;
      for (int off = 1; off <= 6; off++) begin
         @(posedge clk); #1;
         req_valid = 1'b0; kill = (off == kill_at); wired_we = (off == wired_at);
         if (off == 1) begin
            cp0_entry_hi = ~cp0_entry_hi; cp0_entry_lo0 = ~cp0_entry_lo0;
            cp0_entry_lo1 = ~cp0_entry_lo1; cp0_index = ~cp0_index;
         end
         #1;
         if (mmu_in.is_tlbwi && o.wi_off < 0) begin o.wi_off = off; o.wr_idx = mmu_in.index; end
         if (mmu_in.is_tlbwr && o.wr_off < 0) begin o.wr_off = off; o.wr_idx = mmu_in.random; end
         if (off == 2) o.rnd2 = random;
         if (off <= 2) o.busy_all = o.busy_all & busy;
         if (done) begin
            o.done_cnt++;
            if (o.done_off < 0) begin
               o.done_off = off; o.index_we = index_we; o.entry_we = entry_we; o.flush = flush_req;
               o.index_wdata = index_wdata; o.hi = entry_hi_wdata;
               o.lo0 = entry_lo0_wdata; o.lo1 = entry_lo1_wdata;
            end
         end
         if (req_ready && o.ready_off < 0) o.ready_off = off;
      end
      kill = 1'b0; wired_we = 1'b0;
      $display("txn op=%0d kill_at=%0d done_off=%0d flush=%0b index_we=%0b entry_we=%0b idx_wdata=%h lo0=%h wr_idx=%0d",
               op, kill_at, o.done_off, o.flush, o.index_we, o.entry_we, o.index_wdata, o.lo0, o.wr_idx);
   endtask

   task automatic test_reset();
      reset = 1'b1; cp0_wired = 4'd4;
      tick(); tick();
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_checks++; if ({done, flush_req, index_we, entry_we} !== 4'b0) begin n_fail++;
         $display("FAIL reset_pulses got=%b exp=0000", {done, flush_req, index_we, entry_we}); end
      n_checks++; if (random !== 4'd15) begin n_fail++; $display("FAIL reset_random got=%0d exp=15", random); end
      n_checks++; if ({mmu_in.is_tlbwi, mmu_in.is_tlbwr} !== 2'b0) begin n_fail++;
         $display("FAIL reset_mmu_we got=%b exp=00", {mmu_in.is_tlbwi, mmu_in.is_tlbwr}); end
      n_checks++; if ({index_wdata, entry_hi_wdata, entry_lo0_wdata} !== 96'h0) begin n_fail++;
         $display("FAIL reset_data got=%h exp=0", {index_wdata, entry_hi_wdata, entry_lo0_wdata}); end
   endtask

   task automatic test_random_sweep();
      logic [3:0] exp_r;
      reset = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         tick();
         exp_r = 4'(15 - (n % 12));
         n_checks++; if (random !== exp_r) begin n_fail++;
            $display("FAIL random_sweep n=%0d got=%0d exp=%0d", n, random, exp_r); end
      end
      wired_we = 1'b1;
      tick();
      wired_we = 1'b0;
      n_checks++; if (random !== 4'd15) begin n_fail++; $display("FAIL random_wired_we got=%0d exp=15", random); end
      tick();
      n_checks++; if (random !== 4'd14) begin n_fail++; $display("FAIL random_after_we got=%0d exp=14", random); end
   endtask

   task automatic preload();
      for (int i = 0; i < 16; i++) load_entry(i, 32'((i + 1) << 13) | 32'h11, 32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i));
      load_entry(7, 32'hABCD_E055, 32'h0000_7070, 32'h0000_7171);
   endtask

   task automatic test_tlbp();
      obs_t o; exp_t e;
      cp0_entry_hi = 32'hABCD_E055;
      e = '{done_off: 3, ready_off: 4, wi_off: -1, wr_off: -1, wr_idx: '0, index_we: 1'b1, entry_we: 1'b0,
            flush: 1'b0, index_wdata: 32'h0000_0007, hi: '0, lo0: '0, lo1: '0};
      sb.push_back(e);
      run_op(TLBP, -1, -1, o);
      e = sb.pop_front();
      n_checks++; if (o.ready0 !== 1'b1) begin n_fail++; $display("FAIL tlbp_ready0 got=%b exp=1", o.ready0); end
      n_checks++; if (o.busy_all !== 1'b1) begin n_fail++; $display("FAIL tlbp_busy got=%b exp=1", o.busy_all); end
      n_checks++; if (o.done_off !== e.done_off) begin n_fail++; $display("FAIL tlbp_hit_done got=%0d exp=%0d", o.done_off, e.done_off); end
      n_checks++; if (o.index_we !== e.index_we || o.flush !== e.flush) begin n_fail++;
         $display("FAIL tlbp_hit_we got=%b%b exp=%b%b", o.index_we, o.flush, e.index_we, e.flush); end
      n_checks++; if (o.index_wdata !== e.index_wdata) begin n_fail++; $display("FAIL tlbp_hit_index got=%h exp=%h", o.index_wdata, e.index_wdata); end
      n_checks++; if (o.ready_off !== e.ready_off) begin n_fail++; $display("FAIL tlbp_ready_again got=%0d exp=%0d", o.ready_off, e.ready_off); end
      n_checks++; if (o.done_cnt !== 1) begin n_fail++; $display("FAIL tlbp_done_pulse got=%0d exp=1", o.done_cnt); end
      // miss: VPN2 that no entry holds
      cp0_entry_hi = 32'hFFFF_E011;
      e.index_wdata = 32'h8000_0000;
      sb.push_back(e);
      run_op(TLBP, -1, -1, o);
      e = sb.pop_front();
      n_checks++; if (o.done_off !== e.done_off) begin n_fail++; $display("FAIL tlbp_miss_done got=%0d exp=%0d", o.done_off, e.done_off); end
      n_checks++; if (o.index_wdata !== e.index_wdata) begin n_fail++; $display("FAIL tlbp_miss_index got=%h exp=%h", o.index_wdata, e.index_wdata); end
   endtask

   task automatic test_tlbwi_tlbr();
      obs_t o; exp_t e;
      cp0_index = 32'd5; cp0_entry_hi = 32'h1357_A0C3; cp0_entry_lo0 = 32'h0000_5A5F; cp0_entry_lo1 = 32'h0000_A5AF;
      e = '{done_off: 3, ready_off: 4, wi_off: 1, wr_off: -1, wr_idx: 4'd5, index_we: 1'b0, entry_we: 1'b0,
            flush: 1'b1, index_wdata: '0, hi: '0, lo0: '0, lo1: '0};
      sb.push_back(e);
      run_op(TLBWI, -1, -1, o);
      e = sb.pop_front();
      n_checks++; if (o.wi_off !== e.wi_off || o.wr_idx !== e.wr_idx) begin n_fail++;
         $display("FAIL tlbwi_issue got=off%0d idx%0d exp=off%0d idx%0d", o.wi_off, o.wr_idx, e.wi_off, e.wr_idx); end
      n_checks++; if (o.done_off !== e.done_off || o.flush !== e.flush || o.index_we !== e.index_we) begin n_fail++;
         $display("FAIL tlbwi_done got=%0d/%b/%b exp=%0d/%b/%b", o.done_off, o.flush, o.index_we, e.done_off, e.flush, e.index_we); end
      cp0_index = 32'd5;
      e = '{done_off: 3, ready_off: 4, wi_off: -1, wr_off: -1, wr_idx: '0, index_we: 1'b0, entry_we: 1'b1,
            flush: 1'b1, index_wdata: '0, hi: 32'h1357_A0C3, lo0: 32'h0000_5A5F, lo1: 32'h0000_A5AF};
      sb.push_back(e);
      run_op(TLBR, -1, -1, o);
      e = sb.pop_front();
      n_checks++; if (o.done_off !== e.done_off || o.entry_we !== e.entry_we || o.flush !== e.flush) begin n_fail++;
         $display("FAIL tlbr_done got=%0d/%b/%b exp=%0d/%b/%b", o.done_off, o.entry_we, o.flush, e.done_off, e.entry_we, e.flush); end
      n_checks++; if (o.hi !== e.hi || o.lo0 !== e.lo0 || o.lo1 !== e.lo1) begin n_fail++;
         $display("FAIL tlbr_data got=%h %h %h exp=%h %h %h", o.hi, o.lo0, o.lo1, e.hi, e.lo0, e.lo1); end
      n_checks++; if (o.wi_off !== -1 || o.wr_off !== -1) begin n_fail++;
         $display("FAIL tlbr_no_write got=%0d/%0d exp=-1/-1", o.wi_off, o.wr_off); end
   endtask

   task automatic test_tlbwr_snapshot();
      obs_t o; exp_t e;
      int waited = 0;
      cp0_entry_hi = 32'h2468_0077; cp0_entry_lo0 = 32'h0000_1111; cp0_entry_lo1 = 32'h0000_2222;
      while (random !== 4'd9 && waited < 40) begin tick(); waited++; end
      n_checks++; if (random !== 4'd9) begin n_fail++; $display("FAIL tlbwr_wait_random got=%0d exp=9", random); end
      e = '{done_off: 3, ready_off: 4, wi_off: -1, wr_off: 1, wr_idx: 4'd9, index_we: 1'b0, entry_we: 1'b0,
            flush: 1'b1, index_wdata: '0, hi: '0, lo0: '0, lo1: '0};
      sb.push_back(e);
      run_op(TLBWR, -1, 1, o);
      e = sb.pop_front();
      n_checks++; if (o.wr_off !== e.wr_off || o.wr_idx !== e.wr_idx) begin n_fail++;
         $display("FAIL tlbwr_issue got=off%0d idx%0d exp=off%0d idx%0d", o.wr_off, o.wr_idx, e.wr_off, e.wr_idx); end
      n_checks++; if (o.rnd2 !== 4'd15) begin n_fail++; $display("FAIL tlbwr_random_reload got=%0d exp=15", o.rnd2); end
      n_checks++; if (o.done_off !== e.done_off || o.flush !== e.flush) begin n_fail++;
         $display("FAIL tlbwr_done got=%0d/%b exp=%0d/%b", o.done_off, o.flush, e.done_off, e.flush); end
      cp0_index = 32'd9;
      e = '{done_off: 3, ready_off: 4, wi_off: -1, wr_off: -1, wr_idx: '0, index_we: 1'b0, entry_we: 1'b1,
            flush: 1'b1, index_wdata: '0, hi: 32'h2468_0077, lo0: 32'h0000_1111, lo1: 32'h0000_2222};
      sb.push_back(e);
      run_op(TLBR, -1, -1, o);
      e = sb.pop_front();
      n_checks++; if (o.lo0 !== e.lo0 || o.lo1 !== e.lo1 || o.hi !== e.hi) begin n_fail++;
         $display("FAIL tlbwr_readback got=%h %h %h exp=%h %h %h", o.hi, o.lo0, o.lo1, e.hi, e.lo0, e.lo1); end
   endtask

   task automatic test_kill();
      obs_t o; exp_t e;
      cp0_index = 32'd3; cp0_entry_lo0 = 32'hDEAD_0000;
      e = '{done_off: -1, ready_off: 2, wi_off: -1, wr_off: -1, wr_idx: '0, index_we: 1'b0, entry_we: 1'b0,
            flush: 1'b0, index_wdata: '0, hi: '0, lo0: '0, lo1: '0};
      sb.push_back(e);
      run_op(TLBWI, 1, -1, o);
      e = sb.pop_front();
      n_checks++; if (o.wi_off !== e.wi_off) begin n_fail++; $display("FAIL kill_issue_tlbwi got=%0d exp=%0d", o.wi_off, e.wi_off); end
      n_checks++; if (o.done_off !== e.done_off) begin n_fail++; $display("FAIL kill_issue_done got=%0d exp=%0d", o.done_off, e.done_off); end
      n_checks++; if (o.ready_off !== e.ready_off) begin n_fail++; $display("FAIL kill_issue_ready got=%0d exp=%0d", o.ready_off, e.ready_off); end
      e = '{done_off: 3, ready_off: 4, wi_off: -1, wr_off: 1, wr_idx: '0, index_we: 1'b0, entry_we: 1'b0,
            flush: 1'b1, index_wdata: '0, hi: '0, lo0: '0, lo1: '0};
      sb.push_back(e);
      run_op(TLBWR, 2, -1, o);
      e = sb.pop_front();
      n_checks++; if (o.done_off !== e.done_off || o.flush !== e.flush) begin n_fail++;
         $display("FAIL kill_capture_tlbwr got=%0d/%b exp=%0d/%b", o.done_off, o.flush, e.done_off, e.flush); end
      n_checks++; if (o.wr_off !== e.wr_off) begin n_fail++; $display("FAIL kill_capture_wr_issue got=%0d exp=%0d", o.wr_off, e.wr_off); end
      cp0_entry_hi = 32'hABCD_E055;
      e = '{done_off: -1, ready_off: 3, wi_off: -1, wr_off: -1, wr_idx: '0, index_we: 1'b0, entry_we: 1'b0,
            flush: 1'b0, index_wdata: '0, hi: '0, lo0: '0, lo1: '0};
      sb.push_back(e);
      run_op(TLBP, 2, -1, o);
      e = sb.pop_front();
      n_checks++; if (o.done_off !== e.done_off || o.ready_off !== e.ready_off) begin n_fail++;
         $display("FAIL kill_capture_tlbp got=%0d/%0d exp=%0d/%0d", o.done_off, o.ready_off, e.done_off, e.ready_off); end
      // a request presented together with kill must be dropped
      req_valid = 1'b1; kill = 1'b1; req_op = TLBWI;
      tick();
      req_valid = 1'b0; kill = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_idle_drop got=%b exp=0", busy); end
   endtask

   initial begin
      test_reset();
      test_random_sweep();
      preload();
      test_tlbp();
      test_tlbwi_tlbr();
      test_tlbwr_snapshot();
      test_kill();
      n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Multi-cycle sequencer for the MIPS TLB maintenance instructions (TLBP, TLBR, TLBWI, TLBWR). It sits between the memory-stage pipeline and CP0 on one side and the `mmu` TLB-instruction port (`mmu_req_t` / `mmu_resp_t`) on the other. It snapshots the CP0 operands, drives the MMU request for exactly the required cycles, and registers the search/read result. It then commits CP0 writebacks and a pipeline refetch request. It also owns the CP0 Random register.

## Interface
Parameters:
- `TLB_ENTRIES`, 16, number of TLB entries; must equal the `mmu` TLB depth
- `INDEX_W`, 4, `$clog2(TLB_ENTRIES)`; width of `tlb_index_t`

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  pipeline presents a TLB instruction
- `req_op`  in  2  `tlb_op_t`: 0 TLBP, 1 TLBR, 2 TLBWI, 3 TLBWR
- `req_ready`  out  1  block accepts a request; high only in IDLE
- `kill`  in  1  exception/flush from the pipeline for the in-flight instruction
- `cp0_entry_hi`, `cp0_entry_lo0`, `cp0_entry_lo1`, `cp0_index`  in  32 each  current CP0 values
- `cp0_wired`  in  `INDEX_W`  CP0 Wired value
- `wired_we`  in  1  MTC0 to Wired this cycle
- `mmu_in`  out  `mmu_req_t`  request to `mmu`
- `mmu_out`  in  `mmu_resp_t`  TLBP index / TLBR entry from `mmu`; combinational from `mmu_in`
- `random`  out  `INDEX_W`  CP0 Random value, readable by MFC0
- `index_we`  out  1  write CP0 Index; data is `index_wdata` (32)
- `entry_we`  out  1  write CP0 EntryHi/EntryLo0/EntryLo1; data is `entry_hi_wdata`, `entry_lo0_wdata`, `entry_lo1_wdata` (32 each)
- `done`  out  1  one-cycle pulse; the instruction retires
- `flush_req`  out  1  one-cycle pulse with `done` for TLBR/TLBWI/TLBWR; requests a pipeline refetch
- `busy`  out  1  high whenever not IDLE; stalls the pipeline

## Operation
- **FSM states:** IDLE → ISSUE → CAPTURE → COMMIT → IDLE.
- **IDLE:**
  - `req_ready=1`.
  - When `req_valid & ~kill`, latch `req_op`, the four CP0 operands and the current `random` into snapshot registers, then go to ISSUE.
  - `req_valid & kill` is dropped.
- **ISSUE:** `mmu_in` is driven from the snapshot.
  - `mmu_in.is_tlbwi=1` this cycle only when op=TLBWI and `~kill`.
  - `mmu_in.is_tlbwr=1` this cycle only when op=TLBWR and `~kill`.
  - `mmu_in.random` is the snapshot random, not the live counter.
  - For TLBP and TLBR, the combinational `mmu_out` is valid this cycle.
- **CAPTURE:**
  - TLBP: register `mmu_out.index` into `index_wdata` (P bit at [31], index at [INDEX_W-1:0], zeros elsewhere).
  - TLBR: register `mmu_out.entry_hi`, `mmu_out.entry_lo0` and `mmu_out.entry_lo1` into the three entry_*_wdata registers.
  - Writes: no action.
- **COMMIT:**
  - `done=1`.
  - TLBP: `index_we=1`.
  - TLBR: `entry_we=1`, `flush_req=1`.
  - TLBWI/TLBWR: `flush_req=1`.
- **kill:**
  - In ISSUE, any op → IDLE; no TLB write, no outputs.
  - In CAPTURE, TLBP/TLBR → IDLE with no outputs.
  - In CAPTURE or COMMIT, writes → ignored, because the TLB is already modified.
  - In COMMIT, TLBP/TLBR → ignored.
- **`mmu_in` outside ISSUE:** all fields zero, except `entry_hi.asid`, which always carries live `cp0_entry_hi` (the translation ASID).
- **Random counter:**
  - Reset value `TLB_ENTRIES-1`.
  - `wired_we` → `TLB_ENTRIES-1`.
  - `random == cp0_wired` or `cp0_wired >= TLB_ENTRIES-1` → `TLB_ENTRIES-1`.
  - Otherwise it decrements every cycle.
  - It never drops below Wired.
  - Priority: reset > `wired_we` > wrap > decrement.

## Timing
- Accept at cycle T: ISSUE at T+1 (TLB write takes effect at the T+1 edge), CAPTURE at T+2, COMMIT/`done` at T+3, `req_ready` again at T+4.
- Fixed 4-cycle occupancy; no back-to-back acceptance.
- **Reset values:**
  - State IDLE.
  - `random=TLB_ENTRIES-1`.
  - All `*_we`, `done`, `flush_req`, `busy`, and `mmu_in` fields 0.
  - Data registers 0.
- **Reset mid-operation:** returns to IDLE next edge with no writeback. A write already issued in ISSUE is not undone.
- **Simultaneous events:**
  - `wired_we` during ISSUE does not change the snapshot TLBWR index.
  - A `cp0_*` change after acceptance does not affect the in-flight op.

## Structure
- In `mmu_pkg`:
  - `tlb_op_t` enum (2 bits)
  - `tlb_ctrl_state_t` enum (IDLE, ISSUE, CAPTURE, COMMIT)
  - `TLB_ENTRIES` constant shared with `tlb`
- `mmu_req_t` and `mmu_resp_t` are reused unchanged.
- One sub-module: `tlb_random` (Random counter with Wired wrap). The FSM, snapshot and result registers stay in `tlb_op_ctrl`.

## Test plan
- **Reset, then Random sweep:** reset, `cp0_wired=4`, idle 20 cycles → `random` goes 15,14,…,4,15,14,…; `wired_we` pulse → 15 next cycle.
- **TLBP hit:** TLB entry 7 matches `cp0_entry_hi`; TLBP accepted at T → `index_we=1` and `done=1` at T+3, `index_wdata=0x00000007`, `flush_req=0`.
- **TLBP miss:** no match → `index_wdata[31]=1`, `done` at T+3.
- **TLBWI:** `cp0_index=5` → `is_tlbwi=1` only at T+1 with `index=5`; `done` and `flush_req` at T+3; a subsequent TLBR of index 5 returns the written lo0/lo1.
- **TLBWR snapshot:** `random=9` at accept, `wired_we` at T+1 → write goes to entry 9, `random=15` at T+2.
- **Kill:** kill at T+1 of a TLBWI → no `is_tlbwi`, no `done`, `req_ready` at T+2. Kill at T+2 of a TLBWR → `done` and `flush_req` still at T+3.
